paraleloserie_tx: RTL and testbench

- Parallel-to-serial transmitter for the PCIe physical-layer lane; it is the transmit-side counterpart of the serial-to-parallel receiver.
- Accepts 8-bit symbols through a valid/ready handshake and serializes them on the fast clock, one bit per cycle.
- Fills every empty symbol slot with the COM idle symbol (0xBC), so the downstream receiver can acquire and keep byte alignment.
- After reset it sends a fixed run of COM symbols before it accepts any data.

---
 rtl/paraleloserie_tx_pkg.sv | 19 +
 rtl/ps_shift_reg.sv | 56 +++++
 rtl/paraleloserie_tx.sv | 89 ++++++++
 tb/tb_paraleloserie_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paraleloserie_tx_pkg.sv
// Shared definitions for the parallel-to-serial lane transmitter and its
// paired receiver: idle/comma symbol, FSM state encodings and symbol width.
// Bit order is selected at build time by the PS_LSB_FIRST_EN macro; the
// transmitter and the receiver must be built with the same setting.
package paraleloserie_tx_pkg;

    localparam int         PS_WIDTH   = 8;
    localparam logic [7:0] PS_COM_SYM = 8'hBC;

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef PS_LSB_FIRST_EN
    localparam bit PS_LSB_FIRST = 1'b1;
`else
    localparam bit PS_LSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/ps_shift_reg.sv
// Serializer core: WIDTH-bit shift register, free-running bit counter and
// symbol-boundary pulse. A new symbol is loaded on every boundary edge.
// PS_LSB_FIRST_EN selects right shift / LSB output instead of the default
// left shift / MSB output.
module ps_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    output logic             boundary,
    output logic             out
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;

    // Reset parks the counter on the last bit so the first edge after release loads a symbol.
    assign boundary = (bit_cnt == LAST);

    // Bit counter: counts every edge, wraps from the last bit back to zero.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            bit_cnt <= LAST;
        end else if (boundary) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift register: load at the boundary, otherwise shift with zero fill.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (boundary) begin
            shreg <= load_data;
        end else begin
`ifdef PS_LSB_FIRST_EN
            shreg <= {1'b0, shreg[WIDTH-1:1]};
`else
            shreg <= {shreg[WIDTH-2:0], 1'b0};
`endif
        end
    end

`ifdef PS_LSB_FIRST_EN
    assign out = shreg[0];
`else
    assign out = shreg[WIDTH-1];
`endif

endmodule

// File: rtl/paraleloserie_tx.sv
// Parallel-to-serial lane transmitter. Accepts symbols over valid/ready into
// a one-entry holding buffer and serializes them one bit per clk32f edge,
// filling empty slots with the COM symbol. After reset a run of SYNC_COMS
// COM symbols is sent before ready may assert.
// Build option: PS_LSB_FIRST_EN sends symbols LSB first.
//
// state | meaning
// SYNC  | sending the initial COM run, ready held low
// RUN   | normal operation, buffered data replaces COM at each boundary
module paraleloserie_tx
    import paraleloserie_tx_pkg::*;
#(
    parameter int               WIDTH     = PS_WIDTH,
    parameter logic [WIDTH-1:0] COM_SYM   = WIDTH'(PS_COM_SYM),
    parameter int               SYNC_COMS = 4
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready,
    output logic             out,
    output logic             data_active,
    output logic             sync_done
);

    localparam logic [3:0] LAST_COM = 4'(SYNC_COMS - 1);

    logic [0:0]       state;
    logic [3:0]       com_cnt;
    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic             boundary;
    logic             take_buf;
    logic [WIDTH-1:0] next_sym;

    assign take_buf = buf_full && (state == ST_RUN);
    assign next_sym = take_buf ? buf_data : COM_SYM;
    assign ready    = (state == ST_RUN) && !buf_full;

    ps_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk32f    (clk32f),
        .reset     (reset),
        .load_data (next_sym),
        .boundary  (boundary),
        .out       (out)
    );

    // Sync FSM: count COM loads, switch to RUN on the last one of the run.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state     <= ST_SYNC;
            com_cnt   <= '0;
            sync_done <= 1'b0;
        end else if (boundary && (state == ST_SYNC)) begin
            com_cnt <= com_cnt + 1'b1;
            if (com_cnt == LAST_COM) begin
                state     <= ST_RUN;
                sync_done <= 1'b1;
            end
        end
    end

    // Holding buffer: drained at a boundary, filled on a handshake.
    // ready implies empty, so a drain and a capture never share an edge.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (boundary && take_buf) begin
            buf_full <= 1'b0;
        end else if (valid_in && ready) begin
            buf_full <= 1'b1;
            buf_data <= data_in;
        end
    end

    // Tag the symbol being loaded as data or COM.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            data_active <= 1'b0;
        end else if (boundary) begin
            data_active <= take_buf;
        end
    end

endmodule

// File: tb/tb_paraleloserie_tx.sv
module tb_paraleloserie_tx;

    localparam int         W   = 8;
    localparam int         SC  = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready, out, data_active, sync_done;

    int total = 0;
    int bad   = 0;

    always #5 clk32f = ~clk32f;

    paraleloserie_tx #(
        .WIDTH     (W),
        .COM_SYM   (COM),
        .SYNC_COMS (SC)
    ) dut (
        .clk32f      (clk32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready       (ready),
        .out         (out),
        .data_active (data_active),
        .sync_done   (sync_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Symbol-level reference: slot position, current symbol, one pending entry.
    logic [7:0] m_sym;
    logic [7:0] m_pend_data;
    int         m_pos, m_coms, m_edges;
    bit         m_isdata, m_synced, m_pend, m_live, m_took;

    always @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            m_sym = 8'h00; m_pend_data = 8'h00;
            m_pos = W - 1; m_coms = 0; m_edges = 0;
            m_isdata = 0; m_synced = 0; m_pend = 0; m_live = 0; m_took = 0;
        end else begin
            bit can_take;
            can_take = m_synced && !m_pend;
            m_took = 0;
            m_edges++;
            if (m_pos == W - 1) begin
                m_pos = 0;
                m_live = 1;
                if (m_synced && m_pend) begin
                    m_sym = m_pend_data; m_isdata = 1; m_pend = 0;
                end else begin
                    m_sym = COM; m_isdata = 0;
                    if (!m_synced) begin
                        m_coms++;
                        if (m_coms == SC) m_synced = 1;
                    end
                end
            end else begin
                m_pos++;
            end
            if (valid_in && can_take) begin
                m_pend = 1; m_pend_data = data_in; m_took = 1;
            end
        end
    end

    function automatic logic exp_bit();
`ifdef PS_LSB_FIRST_EN
        return m_sym[m_pos];
`else
        return m_sym[W - 1 - m_pos];
`endif
    endfunction

    // Received symbols reassembled from out: {is_data, byte}.
    logic [8:0] slog[$];
    logic [7:0] acc = 8'h00;

    function automatic logic [8:0] ent(input int i);
        if (i < slog.size()) return slog[i];
        return 9'h1FF;
    endfunction

    task automatic step();
        @(negedge clk32f);
        chk("out", out, exp_bit());
        chk("ready", ready, m_synced && !m_pend);
        chk("data_active", data_active, m_isdata);
        chk("sync_done", sync_done, m_synced);
        if (m_live) begin
`ifdef PS_LSB_FIRST_EN
            acc = {out, acc[7:1]};
`else
            acc = {acc[6:0], out};
`endif
            if (m_pos == W - 1) slog.push_back({m_isdata, acc});
        end
    endtask

    task automatic wait_slot(input int pos, input bit need_data);
        bit hit;
        hit = 0;
        for (int i = 0; i < 64; i++) begin
            if (m_pos == pos && ready && (!need_data || data_active)) begin
                hit = 1;
                break;
            end
            step();
        end
        chk("wait_slot_timeout", hit, 1'b1);
    endtask

    task automatic run_sync(input string tag);
        int first_rdy, first_sd, n0;
        first_rdy = -1; first_sd = -1;
        n0 = slog.size();
        for (int i = 0; i < 64; i++) begin
            step();
            if (first_rdy < 0 && ready) first_rdy = m_edges;
            if (first_sd < 0 && sync_done) first_sd = m_edges;
        end
        chk({tag, "_ready_first_edge"}, first_rdy, (SC - 1) * W + 1);
        chk({tag, "_sync_done_edge"}, first_sd, (SC - 1) * W + 1);
        chk({tag, "_slot_count"}, slog.size() - n0, 8);
        for (int i = 0; i < 8; i++) chk({tag, "_com_slot"}, ent(n0 + i), {1'b0, COM});
    endtask

    logic [7:0] sent_q[$];

    initial begin
        int n0, j, idx;
        logic [7:0] b2b [3];
        b2b[0] = 8'h01; b2b[1] = 8'h02; b2b[2] = 8'h03;

        #1 reset = 1'b0;
        #1;
        chk("rst_out", out, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_sync_done", sync_done, 1'b0);
        chk("rst_data_active", data_active, 1'b0);
        step(); step();
        reset = 1'b1;

        run_sync("sync1");

        // Single pulse mid-symbol.
        wait_slot(3, 0);
        n0 = slog.size();
        valid_in = 1'b1; data_in = 8'hA5;
        step();
        valid_in = 1'b0; data_in = $urandom;
        repeat (24) step();
        chk("a5_prev_com", ent(n0), {1'b0, COM});
        chk("a5_data", ent(n0 + 1), 9'h1A5);
        chk("a5_next_com", ent(n0 + 2), {1'b0, COM});

        // Back-to-back with valid held high.
        wait_slot(2, 0);
        n0 = slog.size();
        idx = 0;
        valid_in = 1'b1; data_in = b2b[0];
        for (int i = 0; i < 60 && idx < 3; i++) begin
            step();
            if (m_took) idx++;
            if (idx < 3) data_in = b2b[idx];
            else valid_in = 1'b0;
        end
        valid_in = 1'b0;
        chk("b2b_all_taken", idx, 3);
        repeat (24) step();
        j = n0;
        while (j < slog.size() && !slog[j][8]) j++;
        chk("b2b_sym0", ent(j), 9'h101);
        chk("b2b_sym1", ent(j + 1), 9'h102);
        chk("b2b_sym2", ent(j + 2), 9'h103);
        chk("b2b_after", ent(j + 3), {1'b0, COM});

        // Capture exactly on a boundary edge.
        wait_slot(W - 1, 0);
        n0 = slog.size();
        valid_in = 1'b1; data_in = 8'h3C;
        step();
        valid_in = 1'b0;
        repeat (20) step();
        chk("bnd_current_com", ent(n0), {1'b0, COM});
        chk("bnd_data", ent(n0 + 1), 9'h13C);

        // Reset mid-symbol with 0xFF shifting and 0x55 buffered.
        wait_slot(5, 0);
        valid_in = 1'b1; data_in = 8'hFF;
        step();
        valid_in = 1'b0;
        wait_slot(2, 1);
        valid_in = 1'b1; data_in = 8'h55;
        step();
        valid_in = 1'b0;
        step();
        chk("pre_rst_ff_shifting", data_active, 1'b1);
        chk("pre_rst_buffered", ready, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out", out, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_sync_done", sync_done, 1'b0);
        step(); step();
        reset = 1'b1;
        n0 = slog.size();
        run_sync("sync2");
        for (int i = n0; i < slog.size(); i++) chk("no_stale_55", slog[i], {1'b0, COM});

        // Single 0x01: bit order is visible in the per-cycle out check.
        wait_slot(3, 0);
        n0 = slog.size();
        valid_in = 1'b1; data_in = 8'h01;
        step();
        valid_in = 1'b0;
        repeat (20) step();
        chk("one_data", ent(n0 + 1), 9'h101);

        // Random traffic against the end-to-end scoreboard.
        n0 = slog.size();
        sent_q.delete();
        for (int i = 0; i < 500; i++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            data_in  = ($urandom_range(0, 5) == 0) ? COM : 8'($urandom);
            step();
            if (m_took) sent_q.push_back(m_pend_data);
        end
        valid_in = 1'b0;
        repeat (24) step();
        j = 0;
        for (int i = n0; i < slog.size(); i++) begin
            if (slog[i][8]) begin
                if (j < sent_q.size()) chk("rand_data", slog[i][7:0], sent_q[j]);
                j++;
            end
        end
        chk("rand_count", j, sent_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
